// File: rtl/title_render.sv
// title_render: glyph text-field overlay with marquee scroll over a 2-stage pixel pipeline.
// Define TITLE_BLINK_EN to enable per-slot blinking driven by blink_mask.
module title_render #(
  parameter int N_CHARS = 5,
  parameter int GLYPH_W = 40,
  parameter int GLYPH_H = 40,
  parameter int X0 = 320,
  parameter int Y0 = 10,
  parameter int PITCH = 120,
  parameter logic [15:0] BG_RGB = 16'hFFFF,
  localparam int CW = N_CHARS > 1 ? $clog2(N_CHARS) : 1,
  localparam int RW = $clog2(GLYPH_H)
) (
  input  logic               PixelClk,
  input  logic               nRST,
  input  logic [15:0]        PixelCount,
  input  logic [15:0]        LineCount,
  input  logic               gw_en,
  input  logic [CW-1:0]      gw_char,
  input  logic [RW-1:0]      gw_row,
  input  logic [GLYPH_W-1:0] gw_data,
  input  logic               cw_en,
  input  logic [CW-1:0]      cw_char,
  input  logic [15:0]        cw_rgb,
  input  logic               scroll_en,
  input  logic [N_CHARS-1:0] blink_mask,
  output logic [4:0]         LCD_R,
  output logic [5:0]         LCD_G,
  output logic [4:0]         LCD_B,
  output logic               in_field
);
  localparam int FW = N_CHARS * PITCH;
  localparam int PCW = $clog2(PITCH);
  logic [GLYPH_W-1:0] glyph_q [N_CHARS][GLYPH_H];
  logic [15:0] colour_q [N_CHARS];
  logic [15:0] scroll_q, scroll_d;
  logic [7:0] frame_q, frame_d;
  logic zero_q, fs;
  logic v1_q, hit1_q, hit_d;
  logic [CW-1:0] slot1_q, slot_d;
  logic [PCW-1:0] col1_q, col_d;
  logic [RW-1:0] row1_q, row_d;
  logic [15:0] rgb_q, rgb_d;
  logic in_q, in_d;
  logic [GLYPH_W-1:0] glyph_sh;
  logic blank;
  int px, py, us, u;
`ifdef TITLE_BLINK_EN
  assign blank = blink_mask[slot1_q] & frame_q[5];
`else
  logic unused_blink;
  assign blank = 1'b0;
  assign unused_blink = ^blink_mask;
`endif
  always_comb begin
    px = int'(PixelCount) - X0;
    py = int'(LineCount) - Y0;
    us = px + int'(scroll_q);
    u = us >= FW ? us - FW : us;
    hit_d = px >= 0 && px < FW && py >= 0 && py < GLYPH_H;
    slot_d = CW'(u / PITCH);
    col_d = PCW'(u % PITCH);
    row_d = RW'(py);
    fs = PixelCount == 16'd0 && LineCount == 16'd0 && !zero_q;
    frame_d = fs ? frame_q + 8'd1 : frame_q;
    scroll_d = !(fs && scroll_en) ? scroll_q : int'(scroll_q) == FW - 1 ? 16'd0 : scroll_q + 16'd1;
    // Shifting by the column brings the addressed pixel to the MSB; columns past the glyph shift in zeros.
    glyph_sh = glyph_q[slot1_q][row1_q] << col1_q;
    in_d = v1_q && hit1_q;
    rgb_d = !in_d ? 16'd0 : glyph_sh[GLYPH_W-1] && !blank ? colour_q[slot1_q] : BG_RGB;
  end
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      zero_q <= 1'b0;
      frame_q <= '0;
      scroll_q <= '0;
      v1_q <= 1'b0;
      hit1_q <= 1'b0;
      slot1_q <= '0;
      col1_q <= '0;
      row1_q <= '0;
      rgb_q <= '0;
      in_q <= 1'b0;
      for (int k = 0; k < N_CHARS; k++) colour_q[k] <= 16'hF800;
    end else begin
      zero_q <= PixelCount == 16'd0 && LineCount == 16'd0;
      frame_q <= frame_d;
      scroll_q <= scroll_d;
      v1_q <= 1'b1;
      hit1_q <= hit_d;
      slot1_q <= slot_d;
      col1_q <= col_d;
      row1_q <= row_d;
      rgb_q <= rgb_d;
      in_q <= in_d;
      if (cw_en && int'(cw_char) < N_CHARS) colour_q[cw_char] <= cw_rgb;
    end
  always_ff @(posedge PixelClk)
    if (gw_en && int'(gw_char) < N_CHARS && int'(gw_row) < GLYPH_H) glyph_q[gw_char][gw_row] <= gw_data;
  assign LCD_R = rgb_q[15:11];
  assign LCD_G = rgb_q[10:5];
  assign LCD_B = rgb_q[4:0];
  assign in_field = in_q;
endmodule

// File: tb/tb_title_render.sv
// tb_title_render: directed + randomized checks of title_render against a pixel-level reference model.
module tb_title_render;
  localparam int N = 5, GW = 40, GH = 40, X0 = 320, Y0 = 10, PITCH = 120, FW = N * PITCH;
  localparam logic [15:0] BG = 16'hFFFF;
  logic PixelClk = 1'b0;
  logic nRST = 1'b0;
  logic [15:0] PixelCount = 16'd320, LineCount = 16'd10;
  logic gw_en = 1'b0, cw_en = 1'b0, scroll_en = 1'b0;
  logic [2:0] gw_char = '0, cw_char = '0;
  logic [5:0] gw_row = '0;
  logic [39:0] gw_data = '0;
  logic [15:0] cw_rgb = '0;
  logic [4:0] blink_mask = '0;
  logic [4:0] LCD_R, LCD_B;
  logic [5:0] LCD_G;
  logic in_field;
  logic [39:0] gm [N][GH];
  logic [15:0] cm [N];
  int sx = 0, fc = 0, tests = 0, fails = 0;

  title_render dut (
    .PixelClk(PixelClk), .nRST(nRST), .PixelCount(PixelCount), .LineCount(LineCount),
    .gw_en(gw_en), .gw_char(gw_char), .gw_row(gw_row), .gw_data(gw_data),
    .cw_en(cw_en), .cw_char(cw_char), .cw_rgb(cw_rgb), .scroll_en(scroll_en),
    .blink_mask(blink_mask), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B), .in_field(in_field)
  );

  always #5 PixelClk = ~PixelClk;

  function automatic logic [16:0] model(int x, int y);
    int uu, s, c;
    logic [39:0] g;
    if (x < X0 || x >= X0 + FW || y < Y0 || y >= Y0 + GH) return 17'd0;
    uu = (x - X0 + sx) % FW;
    s = uu / PITCH;
    c = uu % PITCH;
    g = gm[s][y - Y0];
`ifdef TITLE_BLINK_EN
    if (blink_mask[s] && fc[5]) return {1'b1, BG};
`endif
    if (c < GW && g[GW - 1 - c]) return {1'b1, cm[s]};
    return {1'b1, BG};
  endfunction

  task automatic check(string tag, logic [16:0] exp);
    logic [16:0] obs;
    obs = {in_field, LCD_R, LCD_G, LCD_B};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pix(int x, int y);
    @(negedge PixelClk);
    PixelCount = 16'(x);
    LineCount = 16'(y);
    repeat (2) @(posedge PixelClk);
    @(negedge PixelClk);
  endtask

  task automatic wr(logic ge, int gc, int gr, logic [39:0] d, logic ce, int cc, logic [15:0] c);
    @(negedge PixelClk);
    gw_en = ge; gw_char = 3'(gc); gw_row = 6'(gr); gw_data = d;
    cw_en = ce; cw_char = 3'(cc); cw_rgb = c;
    @(negedge PixelClk);
    gw_en = 1'b0; cw_en = 1'b0;
    if (ge && gc < N && gr < GH) gm[gc][gr] = d;
    if (ce && cc < N) cm[cc] = c;
  endtask

  task automatic frame();
    @(negedge PixelClk);
    PixelCount = 16'd0; LineCount = 16'd0;
    @(negedge PixelClk);
    PixelCount = 16'd1;
    fc = (fc + 1) % 256;
    if (scroll_en) sx = (sx + 1) % FW;
  endtask

  initial begin
    int x, y;
    for (int s = 0; s < N; s++) begin
      cm[s] = 16'hF800;
      for (int r = 0; r < GH; r++) gm[s][r] = '0;
    end
    repeat (3) @(negedge PixelClk);
    check("rst_hold", 17'd0);
    nRST = 1'b1;
    pix(320, 10); check("pwr_bg", model(320, 10));
    wr(1, 0, 0, 40'h8000000000, 1, 0, 16'h001F);
    pix(320, 10); check("slot0_blue", 17'h1001F);
    pix(361, 10); check("col41_bg", 17'h1FFFF);
    pix(100, 10); check("outside", 17'd0);
    @(negedge PixelClk); PixelCount = 16'd320;
    @(posedge PixelClk); @(negedge PixelClk); check("lat1", 17'd0);
    @(posedge PixelClk); @(negedge PixelClk); check("lat2", 17'h1001F);
    pix(319, 10); check("left_edge", model(319, 10));
    pix(919, 10); check("right_in", model(919, 10));
    pix(920, 10); check("right_out", model(920, 10));
    pix(320, 9); check("top_out", model(320, 9));
    pix(320, 49); check("bot_in", model(320, 49));
    pix(320, 50); check("bot_out", model(320, 50));
    wr(1, 1, 5, 40'h8000000000, 1, 1, 16'h07E0);
    @(negedge PixelClk); PixelCount = 16'd440; LineCount = 16'd15;
    @(posedge PixelClk);
    @(negedge PixelClk); gw_en = 1'b1; gw_char = 3'd1; gw_row = 6'd5; gw_data = '0;
    @(posedge PixelClk);
    @(negedge PixelClk); gw_en = 1'b0;
    check("coll_old", 17'h107E0);
    gm[1][5] = '0;
    @(posedge PixelClk); @(negedge PixelClk); check("coll_new", model(440, 15));
    for (int i = 0; i < 30; i++) begin
      wr(i % 3 != 2, $urandom_range(0, 7), $urandom_range(0, 47), 40'({$urandom, $urandom}),
         i % 3 != 1, $urandom_range(0, 6), 16'($urandom));
    end
    for (int i = 0; i < 80; i++) begin
      x = $urandom_range(300, 940); y = $urandom_range(5, 55);
      pix(x, y); check("rand_pix", model(x, y));
    end
    wr(1, 0, 0, 40'h8000000000, 1, 0, 16'h001F);
    scroll_en = 1'b1;
    for (int f = 1; f <= FW; f++) begin
      frame();
      if (f == 1 || f == 300 || f == 599 || f == 600) begin
        pix(320, 10); check("scroll_a", model(320, 10));
        pix(321, 10); check("scroll_b", model(321, 10));
        x = $urandom_range(320, 919); y = $urandom_range(10, 49);
        pix(x, y); check("scroll_rand", model(x, y));
      end
    end
    pix(320, 10); check("wrap600", 17'h1001F);
    scroll_en = 1'b0;
    frame(); frame();
    pix(320, 10); check("scroll_hold", model(320, 10));
    @(negedge PixelClk); #2 nRST = 1'b0;
    #1 check("rst_async", 17'd0);
    sx = 0; fc = 0;
    for (int s = 0; s < N; s++) cm[s] = 16'hF800;
    repeat (2) @(negedge PixelClk);
    check("rst_low", 17'd0);
    nRST = 1'b1;
    @(posedge PixelClk); @(negedge PixelClk); check("rst_lat1", 17'd0);
    @(posedge PixelClk); @(negedge PixelClk); check("rst_red", 17'h1F800);
    for (int i = 0; i < 20; i++) begin
      x = $urandom_range(320, 919); y = $urandom_range(10, 49);
      pix(x, y); check("retain", model(x, y));
    end
    blink_mask = 5'b00001;
    wr(1, 1, 0, 40'h8000000000, 0, 0, 16'h0000);
    for (int f = 1; f <= 64; f++) begin
      frame();
      if (f == 31 || f == 32 || f == 63 || f == 64) begin
        pix(320, 10); check("blink_s0", model(320, 10));
        pix(440, 10); check("blink_s1", model(440, 10));
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
